// File: rtl/bit_synchro.sv
// -----------------------------------------------------------------------------
// bit_synchro
//
// Multi-flop synchronizer that brings an asynchronous single-bit level into
// the clk domain. It also produces registered rise/fall pulses of the
// synchronized level. All flops are posedge; for a negedge domain, pass an
// inverted clock.
//
// Parameters
//   INITIALIZE : "LOGIC1" resets every flop to 1; any other string resets to 0.
//   STAGES     : number of synchronizing flops (2..8).
//
// Ports
//   clk        : sampling clock
//   rst_n      : asynchronous active-low reset
//   async      : asynchronous level input
//   sync       : synchronized level (last chain stage)
//   sync_rise  : one-clk pulse when sync goes 0->1
//   sync_fall  : one-clk pulse when sync goes 1->0
// -----------------------------------------------------------------------------
module bit_synchro #(
    parameter string       INITIALIZE = "LOGIC0",
    parameter int unsigned STAGES     = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async,
    output logic sync,
    output logic sync_rise,
    output logic sync_fall
);

    // Reject illegal chain lengths at elaboration.
    if (STAGES < 2 || STAGES > 8) begin : g_bad_stages
        $fatal(1, "bit_synchro: STAGES must be in the range 2..8");
    end

    localparam logic InitVal = (INITIALIZE == "LOGIC1") ? 1'b1 : 1'b0;

    // Chain flops must stay adjacent and must not be retimed or mapped into
    // shift-register primitives, or the metastability settling time is lost.
    (* ASYNC_REG = "TRUE", shreg_extract = "no", dont_touch = "true" *)
    logic [STAGES-1:0] chain_q;
    logic [STAGES-1:0] chain_d;

    // Previous value of sync. It resets to the same value as the chain, so
    // no edge pulse appears when reset is released.
    logic sync_hist_q;
    logic sync_hist_d;

    always_comb begin
        chain_d     = {chain_q[STAGES-2:0], async};
        sync_hist_d = chain_q[STAGES-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain_q     <= {STAGES{InitVal}};
            sync_hist_q <= InitVal;
        end else begin
            chain_q     <= chain_d;
            sync_hist_q <= sync_hist_d;
        end
    end

    // Outputs are decoded from flops only; there is no combinational path
    // from async.
    always_comb begin
        sync      = chain_q[STAGES-1];
        sync_rise = chain_q[STAGES-1] & ~sync_hist_q;
        sync_fall = ~chain_q[STAGES-1] & sync_hist_q;
    end

endmodule

// File: tb/tb_bit_synchro.sv
// -----------------------------------------------------------------------------
// tb_bit_synchro
//
// Scoreboard bench for bit_synchro. Four instances share async and rst_n:
//   A: LOGIC0, 2 stages      B: LOGIC1, 3 stages
//   C: "FOO" (-> 0), 5 stages D: LOGIC0, 2 stages on the inverted clock
// Inputs change 2 time units after a posedge. The next D edge (negedge) and
// the next A/B/C edge (posedge) therefore sample the same async value.
// The reference model keeps the list of async values sampled since the
// last reset release. After k such edges, sync equals the value sampled at
// edge k-STAGES+1, or INIT while fewer than STAGES edges have happened.
// -----------------------------------------------------------------------------
module tb_bit_synchro;

    logic clk    = 1'b1;
    logic clk_en = 1'b0;
    logic rst_n  = 1'b1;
    logic async  = 1'b1;
    logic clk_n;

    assign clk_n = ~clk;

    logic a_sync, a_rise, a_fall;
    logic b_sync, b_rise, b_fall;
    logic c_sync, c_rise, c_fall;
    logic d_sync, d_rise, d_fall;

    int checks = 0;
    int errors = 0;

    logic [8:0] pos_q[$];   // {A, B, C} expected {sync, rise, fall}
    logic [2:0] neg_q[$];   // D expected {sync, rise, fall}
    bit         samples[$]; // async values sampled since reset release
    bit         in_reset = 1'b0;

    bit_synchro #(.INITIALIZE("LOGIC0"), .STAGES(2)) u_a (
        .clk(clk), .rst_n(rst_n), .async(async),
        .sync(a_sync), .sync_rise(a_rise), .sync_fall(a_fall)
    );

    bit_synchro #(.INITIALIZE("LOGIC1"), .STAGES(3)) u_b (
        .clk(clk), .rst_n(rst_n), .async(async),
        .sync(b_sync), .sync_rise(b_rise), .sync_fall(b_fall)
    );

    bit_synchro #(.INITIALIZE("FOO"), .STAGES(5)) u_c (
        .clk(clk), .rst_n(rst_n), .async(async),
        .sync(c_sync), .sync_rise(c_rise), .sync_fall(c_fall)
    );

    bit_synchro #(.INITIALIZE("LOGIC0"), .STAGES(2)) u_d (
        .clk(clk_n), .rst_n(rst_n), .async(async),
        .sync(d_sync), .sync_rise(d_rise), .sync_fall(d_fall)
    );

    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    // Expected {sync, rise, fall} after the edge about to happen.
    function automatic logic [2:0] model(input int st, input bit init);
        int k;
        bit cur;
        bit prev;
        k = samples.size();
        if (in_reset) return {init, 2'b00};
        cur  = (k >= st)     ? samples[k - st]     : init;
        prev = (k - 1 >= st) ? samples[k - 1 - st] : init;
        return {cur, cur & ~prev, ~cur & prev};
    endfunction

    task automatic push_expect();
        pos_q.push_back({model(2, 1'b0), model(3, 1'b1), model(5, 1'b0)});
        neg_q.push_back(model(2, 1'b0));
    endtask

    task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s sync/rise/fall got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Called at posedge+2: drive async, record what the next edges sample.
    task automatic step(input bit a);
        async = a;
        if (!in_reset) samples.push_back(a);
        push_expect();
        @(posedge clk);
        #2;
    endtask

    // Asynchronous reset assertion mid-cycle. The first expectation is for
    // the immediate check. The second is for the clock edges of this cycle.
    task automatic assert_reset();
        #1;
        in_reset = 1'b1;
        samples.delete();
        push_expect();
        rst_n = 1'b0;
        push_expect();
        @(posedge clk);
        #2;
    endtask

    task automatic release_reset();
        rst_n    = 1'b1;
        in_reset = 1'b0;
        samples.delete();
    endtask

    // Posedge-domain monitor (A, B, C); also fires on async reset.
    initial begin
        logic [8:0] e;
        forever begin
            @(posedge clk or negedge rst_n);
            #1;
            if (pos_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pos_scoreboard got empty queue expected entry at %0t", $time);
            end else begin
                e = pos_q.pop_front();
                check("A_l0_s2", {a_sync, a_rise, a_fall}, e[8:6]);
                check("B_l1_s3", {b_sync, b_rise, b_fall}, e[5:3]);
                check("C_foo_s5", {c_sync, c_rise, c_fall}, e[2:0]);
            end
        end
    end

    // Inverted-clock monitor (D).
    initial begin
        logic [2:0] e;
        forever begin
            @(negedge clk or negedge rst_n);
            #1;
            if (neg_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL neg_scoreboard got empty queue expected entry at %0t", $time);
            end else begin
                e = neg_q.pop_front();
                check("D_invclk", {d_sync, d_rise, d_fall}, e);
            end
        end
    end

    initial begin
        // Reset with async=1 and no clock edges at all.
        #1;
        in_reset = 1'b1;
        push_expect();
        rst_n = 1'b0;
        #2;
        clk_en = 1'b1;

        // Clocks run while reset is held.
        repeat (3) step(1'b1);

        // Latency and rise: raise async before the first edge after release.
        release_reset();
        repeat (8) step(1'b1);

        // Fall.
        repeat (8) step(1'b0);

        // Mid-flight reset: a rise enters the chain, then reset discards it.
        step(1'b1);
        assert_reset();
        repeat (2) step(1'b1);
        release_reset();
        repeat (8) step(1'b1);

        // Randomized levels and holds, with occasional resets.
        for (int i = 0; i < 80; i++) begin
            bit v;
            int hold;
            v    = 1'($urandom_range(0, 1));
            hold = int'($urandom_range(1, 6));
            repeat (hold) step(v);
            if ($urandom_range(0, 11) == 0) begin
                assert_reset();
                step(1'($urandom_range(0, 1)));
                release_reset();
            end
        end

        // Let the last expectations drain, then confirm nothing is left.
        repeat (2) step(async);
        checks++;
        if (pos_q.size() + neg_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d left expected 0",
                     pos_q.size() + neg_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
